// File: rtl/evp_fsm_pkg.sv
// Shared EVP/STP definitions: geometry, status codes, width helper and EVP state encoding.
package evp_fsm_pkg;

  localparam int unsigned WORD_SIZE = 16;
  localparam int unsigned N_SIZE    = 8;
  localparam int unsigned S_SIZE    = 88;
  localparam int unsigned POLY_LEN  = 11;
  localparam int unsigned ACC_W     = 32;
  localparam int unsigned LEN_W     = 5;

  localparam logic [31:0] STATUS_OK      = 32'd0;
  localparam logic [31:0] STATUS_INVALID = 32'd2;
  localparam logic [31:0] STATUS_RESET   = 32'hFFFF_FFFF;

  // Smallest r with 2**r >= v.
  function automatic int unsigned log2_ceil(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

  localparam int unsigned N_AW = log2_ceil(N_SIZE);
  localparam int unsigned S_AW = log2_ceil(S_SIZE);
  localparam int unsigned K_W  = log2_ceil(POLY_LEN);

  typedef enum logic [2:0] {
    EVP_IDLE,
    EVP_RD_N,
    EVP_CHK_N,
    EVP_ACC,
    EVP_ERR,
    EVP_DONE
  } evp_state_e;

endpackage

// File: rtl/evp_mac.sv
// Horner step acc*x + sext(c), truncated to the accumulator width.
module evp_mac
  import evp_fsm_pkg::*;
(
  input  logic [ACC_W-1:0]     acc,
  input  logic [WORD_SIZE-1:0] x,
  input  logic [WORD_SIZE-1:0] c,
  output logic [ACC_W-1:0]     acc_nxt_c
);

  logic [ACC_W-1:0] x_ext;
  logic [ACC_W-1:0] c_ext;

  // Low 32 bits of a signed product equal those of the product of sign-extended operands.
  assign x_ext     = {{(ACC_W-WORD_SIZE){x[WORD_SIZE-1]}}, x};
  assign c_ext     = {{(ACC_W-WORD_SIZE){c[WORD_SIZE-1]}}, c};
  assign acc_nxt_c = acc * x_ext + c_ext;

endmodule

// File: rtl/evp_fsm.sv
// EVP instruction: fetch polynomial length and coefficients from N/S RAM, evaluate by Horner's rule.
module evp_fsm
  import evp_fsm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_evp,
  input  logic [N_AW-1:0]      A,
  input  logic [WORD_SIZE-1:0] x,
  input  logic [LEN_W-1:0]     rd_data_N,
  input  logic [WORD_SIZE-1:0] rd_data_S,
  output logic                 en_rd_N,
  output logic [N_AW-1:0]      rd_addr_N,
  output logic                 en_rd_S,
  output logic [S_AW-1:0]      rd_addr_S,
  output logic [31:0]          result,
  output logic [31:0]          status,
  output logic                 wr_en_result,
  output logic                 wr_en_status,
  output logic                 done_evp
);

  evp_state_e state_q, state_d;

  logic [N_AW-1:0]      a_q;
  logic [WORD_SIZE-1:0] x_q;
  logic [K_W-1:0]       k_q;
  logic [ACC_W-1:0]     acc_q;
  logic [ACC_W-1:0]     mac_c;
  logic                 len_ok_c;
  logic [S_AW-1:0]      base_c;
  logic                 done_d;
  logic [31:0]          result_d;
  logic [31:0]          status_d;

  assign len_ok_c = (rd_data_N != '0) && (rd_data_N <= LEN_W'(POLY_LEN));
  assign base_c   = S_AW'(a_q) * S_AW'(POLY_LEN);

  evp_mac u_mac (
    .acc       (acc_q),
    .x         (x_q),
    .c         (rd_data_S),
    .acc_nxt_c (mac_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= EVP_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EVP_IDLE:  if (start_evp) state_d = EVP_RD_N;
      EVP_RD_N:  state_d = EVP_CHK_N;
      EVP_CHK_N: state_d = len_ok_c ? EVP_ACC : EVP_ERR;
      EVP_ACC:   if (k_q == '0) state_d = EVP_DONE;
      EVP_ERR:   state_d = EVP_DONE;
      EVP_DONE:  state_d = EVP_IDLE;
      default:   state_d = EVP_IDLE;
    endcase
  end

  // RAM ports are driven combinationally so the S read can issue in the cycle L arrives.
  always_comb begin
    en_rd_N   = 1'b0;
    rd_addr_N = '0;
    en_rd_S   = 1'b0;
    rd_addr_S = '0;
    done_d    = 1'b0;
    result_d  = mac_c;
    status_d  = STATUS_OK;
    case (state_q)
      EVP_RD_N: begin
        en_rd_N   = 1'b1;
        rd_addr_N = a_q;
      end
      EVP_CHK_N: begin
        if (len_ok_c) begin
          en_rd_S   = 1'b1;
          rd_addr_S = base_c + S_AW'(rd_data_N) - S_AW'(1);
        end
      end
      EVP_ACC: begin
        if (k_q != '0) begin
          en_rd_S   = 1'b1;
          rd_addr_S = base_c + S_AW'(k_q) - S_AW'(1);
        end else begin
          done_d = 1'b1;
        end
      end
      EVP_ERR: begin
        done_d   = 1'b1;
        result_d = '0;
        status_d = STATUS_INVALID;
      end
      default: ;
    endcase
  end

  // Operand latches, counter, accumulator and registered completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q          <= '0;
      x_q          <= '0;
      k_q          <= '0;
      acc_q        <= '0;
      result       <= '0;
      status       <= STATUS_RESET;
      done_evp     <= 1'b0;
      wr_en_result <= 1'b0;
      wr_en_status <= 1'b0;
    end else begin
      done_evp     <= done_d;
      wr_en_result <= done_d;
      wr_en_status <= done_d;
      if (done_d) begin
        result <= result_d;
        status <= status_d;
      end
      case (state_q)
        EVP_IDLE: begin
          if (start_evp) begin
            a_q <= A;
            x_q <= x;
          end
        end
        EVP_CHK_N: begin
          k_q   <= K_W'(rd_data_N - LEN_W'(1));
          acc_q <= '0;
        end
        EVP_ACC: begin
          acc_q <= mac_c;
          if (k_q != '0) k_q <= k_q - K_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_evp_fsm.sv
// Scoreboard bench for evp_fsm: RAM models, power-sum reference model, directed and random instructions.
module tb_evp_fsm;
  import evp_fsm_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_evp;
  logic [2:0]  A;
  logic [15:0] x;
  logic [4:0]  rd_data_N = '0;
  logic [15:0] rd_data_S = '0;
  logic        en_rd_N, en_rd_S;
  logic [2:0]  rd_addr_N;
  logic [6:0]  rd_addr_S;
  logic [31:0] result, status;
  logic        wr_en_result, wr_en_status, done_evp;

  evp_fsm dut (
    .clk(clk), .rst(rst), .start_evp(start_evp), .A(A), .x(x),
    .rd_data_N(rd_data_N), .rd_data_S(rd_data_S),
    .en_rd_N(en_rd_N), .rd_addr_N(rd_addr_N),
    .en_rd_S(en_rd_S), .rd_addr_S(rd_addr_S),
    .result(result), .status(status),
    .wr_en_result(wr_en_result), .wr_en_status(wr_en_status),
    .done_evp(done_evp)
  );

  always #5 clk = ~clk;

  logic [4:0]  n_mem [8];
  logic [15:0] s_mem [88];

  always @(posedge clk) begin
    if (en_rd_N) rd_data_N <= n_mem[rd_addr_N];
    if (en_rd_S) rd_data_S <= s_mem[rd_addr_S];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [31:0] st;
    int lat;
    int start;
    int nrd;
    int first;
    int last;
    int naddr;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: sum of c_k * x^k, everything modulo 2^32.
  function automatic exp_t model(input int a, input logic [15:0] xv, input int s);
    exp_t e;
    int len;
    logic [31:0] pw, sum, c, xe;
    len = int'(n_mem[a]);
    e.start = s;
    e.naddr = a;
    if (len == 0 || len > 11) begin
      e.res = 32'd0; e.st = 32'd2; e.lat = 4; e.nrd = 0; e.first = 0; e.last = 0;
    end else begin
      xe = {{16{xv[15]}}, xv};
      pw = 32'd1;
      sum = 32'd0;
      for (int k = 0; k < len; k++) begin
        c = {{16{s_mem[a*11+k][15]}}, s_mem[a*11+k]};
        sum = sum + c * pw;
        pw = pw * xe;
      end
      e.res = sum; e.st = 32'd0; e.lat = len + 3; e.nrd = len;
      e.first = a*11 + len - 1; e.last = a*11;
    end
    return e;
  endfunction

  // Monitor: tracks RAM reads and checks each completion against the scoreboard.
  initial begin
    int nrd, first, last, naddr;
    exp_t e;
    nrd = 0; first = 0; last = 0; naddr = -1;
    forever begin
      @(negedge clk);
      if (rst) begin
        nrd = 0; naddr = -1;
      end else begin
        if (en_rd_N) naddr = int'(rd_addr_N);
        if (en_rd_S) begin
          if (nrd == 0) first = int'(rd_addr_S);
          last = int'(rd_addr_S);
          nrd++;
        end
        if (wr_en_result !== done_evp || wr_en_status !== done_evp)
          check("wr_en_vs_done", {30'd0, wr_en_result, wr_en_status}, {30'd0, done_evp, done_evp});
        if (done_evp) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("result", result, e.res);
            check("status", status, e.st);
            check("latency", 32'(cyc - e.start), 32'(e.lat));
            check("n_addr", 32'(naddr), 32'(e.naddr));
            check("s_reads", 32'(nrd), 32'(e.nrd));
            if (e.nrd > 0) begin
              check("s_first_addr", 32'(first), 32'(e.first));
              check("s_last_addr", 32'(last), 32'(e.last));
            end
          end
          nrd = 0; naddr = -1;
        end
      end
    end
  end

  task automatic issue(input int a, input logic [15:0] xv, output int s);
    @(posedge clk); #1;
    A = 3'(a); x = xv; start_evp = 1'b1;
    s = cyc;
    sb.push_back(model(a, xv, s));
    @(posedge clk); #1;
    start_evp = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      check("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic fill(input int a, input int len);
    n_mem[a] = 5'(len);
    for (int k = 0; k < 11; k++) s_mem[a*11+k] = 16'($urandom);
  endtask

  initial begin
    int s, a, len;
    for (int i = 0; i < 8; i++) n_mem[i] = '0;
    for (int i = 0; i < 88; i++) s_mem[i] = '0;
    rst = 1'b1; start_evp = 1'b0; A = '0; x = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", result, 32'd0);
    check("rst_status", status, 32'hFFFF_FFFF);
    check("rst_outs", {27'd0, done_evp, wr_en_result, wr_en_status, en_rd_N, en_rd_S}, 32'd0);
    check("rst_addr", {22'd0, rd_addr_N, rd_addr_S}, 32'd0);
    rst = 1'b0;

    // Normal evaluation: 1*25 + 2*5 + 3.
    n_mem[2] = 5'd3; s_mem[22] = 16'd3; s_mem[23] = 16'd2; s_mem[24] = 16'd1;
    issue(2, 16'd5, s); wait_done();
    check("normal_value", result, 32'd38);

    // Constant polynomial, then negative x.
    n_mem[0] = 5'd1; s_mem[0] = 16'hFFF9;
    issue(0, 16'd100, s); wait_done();
    check("const_value", result, 32'hFFFF_FFF9);
    n_mem[1] = 5'd2; s_mem[11] = 16'd1; s_mem[12] = 16'hFFFF;
    issue(1, 16'hFFFD, s); wait_done();
    check("neg_x_value", result, 32'd4);

    // Invalid lengths.
    n_mem[3] = 5'd0;
    issue(3, 16'd9, s); wait_done();
    check("len0_status", status, 32'd2);
    n_mem[3] = 5'd12;
    issue(3, 16'd9, s); wait_done();
    check("len12_status", status, 32'd2);

    // Highest slot with full length and wrapping arithmetic.
    n_mem[7] = 5'd11;
    for (int k = 0; k < 11; k++) s_mem[77+k] = 16'h7FFF;
    issue(7, 16'h7FFF, s); wait_done();

    // Second start during ACC is ignored.
    fill(4, 6);
    issue(4, 16'($urandom), s);
    while (cyc < s + 4) begin @(posedge clk); #1; end
    A = 3'd1; x = 16'($urandom); start_evp = 1'b1;
    @(posedge clk); #1;
    start_evp = 1'b0;
    wait_done();
    repeat (20) @(posedge clk);

    // Reset during ACC aborts without a completion.
    fill(5, 8);
    @(posedge clk); #1;
    A = 3'd5; x = 16'd3; start_evp = 1'b1; s = cyc;
    @(posedge clk); #1;
    start_evp = 1'b0;
    while (cyc < s + 5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_status", status, 32'hFFFF_FFFF);
    check("midrst_result", result, 32'd0);
    check("midrst_outs", {29'd0, done_evp, en_rd_N, en_rd_S}, 32'd0);
    repeat (20) @(posedge clk);
    issue(5, 16'hFFFE, s); wait_done();

    // Random instructions, occasionally with invalid lengths.
    for (int t = 0; t < 30; t++) begin
      a = int'($urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(12, 31));
      else len = int'($urandom_range(1, 11));
      fill(a, len);
      issue(a, 16'($urandom), s);
      wait_done();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
